// File: rtl/id_alu_issue.sv
// id_alu_issue: decodes RV64I integer-computational instructions into the
// one-hot ALU operation and operand bundle, held in a single ID/EX register
// with valid/ready handshakes on both sides and a flush that kills the entry.
module id_alu_issue #(
  parameter int XLEN = 64,
  parameter int OPW  = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OPW-1:0]  alu_op,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic            alu_32,
  output logic [4:0]      rd,
  output logic            rf_we,
  output logic            illegal
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(1 << 11);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1 << 10);
  localparam logic [OPW-1:0] OP_SLT  = OPW'(1 << 9);
  localparam logic [OPW-1:0] OP_SLTU = OPW'(1 << 8);
  localparam logic [OPW-1:0] OP_AND  = OPW'(1 << 7);
  localparam logic [OPW-1:0] OP_OR   = OPW'(1 << 6);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(1 << 5);
  localparam logic [OPW-1:0] OP_SLL  = OPW'(1 << 4);
  localparam logic [OPW-1:0] OP_SRL  = OPW'(1 << 3);
  localparam logic [OPW-1:0] OP_SRA  = OPW'(1 << 2);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(1 << 1);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [5:0]      funct6;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt6;
  logic [XLEN-1:0] shamt5;

  // The rs1 index is resolved by the regfile upstream; only its data arrives here.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^inst[19:15];

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign funct6 = inst[31:26];
  assign imm_i  = {{(XLEN-12){inst[31]}}, inst[31:20]};
  assign imm_u  = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
  assign shamt6 = {{(XLEN-6){1'b0}}, inst[25:20]};
  assign shamt5 = {{(XLEN-5){1'b0}}, inst[24:20]};

  logic [OPW-1:0]  raw_op;
  logic [XLEN-1:0] raw_src1;
  logic [XLEN-1:0] raw_src2;
  logic            raw_32;
  logic            raw_ill;

  // Raw decode: operation, operands and W-form flag before illegal masking.
  always_comb begin
    raw_op   = '0;
    raw_src1 = '0;
    raw_src2 = '0;
    raw_32   = 1'b0;
    raw_ill  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        raw_op   = OP_NOP;
        raw_src2 = imm_u;
      end
      OPC_AUIPC: begin
        raw_op   = OP_ADD;
        raw_src1 = pc;
        raw_src2 = imm_u;
      end
      OPC_OPIMM: begin
        raw_src1 = rs1_data;
        raw_src2 = imm_i;
        case (funct3)
          3'b000: raw_op = OP_ADD;
          3'b010: raw_op = OP_SLT;
          3'b011: raw_op = OP_SLTU;
          3'b100: raw_op = OP_XOR;
          3'b110: raw_op = OP_OR;
          3'b111: raw_op = OP_AND;
          3'b001: begin
            raw_src2 = shamt6;
            if (funct6 == 6'b000000) raw_op = OP_SLL;
            else                     raw_ill = 1'b1;
          end
          default: begin
            raw_src2 = shamt6;
            if (funct6 == 6'b000000)      raw_op = OP_SRL;
            else if (funct6 == 6'b010000) raw_op = OP_SRA;
            else                          raw_ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        raw_src1 = rs1_data;
        raw_src2 = rs2_data;
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000: raw_op = OP_ADD;
            3'b001: raw_op = OP_SLL;
            3'b010: raw_op = OP_SLT;
            3'b011: raw_op = OP_SLTU;
            3'b100: raw_op = OP_XOR;
            3'b101: raw_op = OP_SRL;
            3'b110: raw_op = OP_OR;
            default: raw_op = OP_AND;
          endcase
        end else if (funct7 == F7_ALT) begin
          case (funct3)
            3'b000: raw_op = OP_SUB;
            3'b101: raw_op = OP_SRA;
            default: raw_ill = 1'b1;
          endcase
        end else begin
          raw_ill = 1'b1;
        end
      end
      OPC_OPIMM32: begin
        raw_32   = 1'b1;
        raw_src1 = rs1_data;
        case (funct3)
          3'b000: begin
            raw_op   = OP_ADD;
            raw_src2 = imm_i;
          end
          3'b001: begin
            raw_src2 = shamt5;
            if (funct7 == F7_BASE) raw_op = OP_SLL;
            else                   raw_ill = 1'b1;
          end
          3'b101: begin
            raw_src2 = shamt5;
            if (funct7 == F7_BASE)     raw_op = OP_SRL;
            else if (funct7 == F7_ALT) raw_op = OP_SRA;
            else                       raw_ill = 1'b1;
          end
          default: raw_ill = 1'b1;
        endcase
      end
      OPC_OP32: begin
        raw_32   = 1'b1;
        raw_src1 = rs1_data;
        raw_src2 = rs2_data;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: raw_op = OP_ADD;
          {F7_ALT,  3'b000}: raw_op = OP_SUB;
          {F7_BASE, 3'b001}: raw_op = OP_SLL;
          {F7_BASE, 3'b101}: raw_op = OP_SRL;
          {F7_ALT,  3'b101}: raw_op = OP_SRA;
          default:           raw_ill = 1'b1;
        endcase
      end
      default: raw_ill = 1'b1;
    endcase
  end

  logic [OPW-1:0]  dec_op;
  logic [XLEN-1:0] dec_src1;
  logic [XLEN-1:0] dec_src2;
  logic            dec_32;
  logic            dec_we;

  // Illegal encodings carry an all-zero bundle so EX cannot act on stale operands.
  always_comb begin
    dec_op   = raw_op;
    dec_src1 = raw_src1;
    dec_src2 = raw_src2;
    dec_32   = raw_32;
    dec_we   = (inst[11:7] != 5'd0);
    if (raw_ill) begin
      dec_op   = '0;
      dec_src1 = '0;
      dec_src2 = '0;
      dec_32   = 1'b0;
      dec_we   = 1'b0;
    end
  end

  logic            valid_q, valid_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] src1_q, src1_d;
  logic [XLEN-1:0] src2_q, src2_d;
  logic            w32_q, w32_d;
  logic [4:0]      rd_q, rd_d;
  logic            we_q, we_d;
  logic            ill_q, ill_d;
  logic            accept;

  assign in_ready = ~flush & (~valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  // Next-state of the ID/EX register: load on accept, drain on consume, kill on flush.
  always_comb begin
    valid_d = valid_q & ~out_ready;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    w32_d   = w32_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ill_d   = ill_q;
    if (accept) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      src1_d  = dec_src1;
      src2_d  = dec_src2;
      w32_d   = dec_32;
      rd_d    = inst[11:7];
      we_d    = dec_we;
      ill_d   = raw_ill;
    end
    if (flush) valid_d = 1'b0;
  end

  // Pipeline register with synchronous reset clearing the whole bundle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      w32_q   <= 1'b0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      w32_q   <= w32_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ill_q   <= ill_d;
    end
  end

  assign out_valid = valid_q;
  assign alu_op    = op_q;
  assign alu_src1  = src1_q;
  assign alu_src2  = src2_q;
  assign alu_32    = w32_q;
  assign rd        = rd_q;
  assign rf_we     = we_q;
  assign illegal   = ill_q;

endmodule

// File: doc/id_alu_issue.md
Name: id_alu_issue

Overview:
- Issue-side decode stage that produces the ALU operand/opcode bundle (alu_op, alu_src1, alu_src2, alu_32) consumed by the execute-stage ALU.
- Decodes RV64I integer-computational instructions (OP, OP-IMM, OP-32, OP-IMM-32, LUI, AUIPC) and registers the result in a single-entry ID/EX pipeline register.
- Upstream (fetch/regfile read) and downstream (EX) connect through valid/ready handshakes; a flush input kills the held entry.

Parameters:
- XLEN, 64, operand/PC width
- OPW, 14, alu_op width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill held entry, drop incoming
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- inst  in  32  instruction word
- pc  in  XLEN  instruction PC
- rs1_data  in  XLEN  regfile read port 1
- rs2_data  in  XLEN  regfile read port 2
- out_valid  out  1  EX bundle valid
- out_ready  in  1  EX accepts
- alu_op  out  OPW  one-hot op: [11]add [10]sub [9]slt [8]sltu [7]and [6]or [5]xor [4]sll [3]srl [2]sra [1]nop(pass src2) [0]sp(never set); [13:12] always 0
- alu_src1  out  XLEN  operand 1
- alu_src2  out  XLEN  operand 2
- alu_32  out  1  W-form op
- rd  out  5  destination register
- rf_we  out  1  writeback enable
- illegal  out  1  unsupported encoding

Behaviour:
- Reset (rst=1 at posedge): out_valid=0; alu_op, alu_src1, alu_src2, alu_32, rd, rf_we, illegal all 0. rst overrides flush and handshakes.
- in_ready = ~flush & (~out_valid | out_ready), combinational.
- Accept when in_valid & in_ready: decoded bundle registered at that edge; out_valid=1 next cycle. Latency 1 cycle.
- Drain when out_valid & out_ready with no accept: out_valid→0. Simultaneous drain and accept: new bundle replaces old, out_valid stays 1 (full throughput).
- Stall: out_valid & ~out_ready holds every output bit-stable.
- flush=1 (rst=0): out_valid→0 next edge, in_ready=0, incoming instruction discarded; payload registers may retain values.
- Decode (opcode inst[6:0]):
  - LUI 0110111: nop; src1=0; src2=sext(inst[31:12]<<12).
  - AUIPC 0010111: add; src1=pc; src2=sext(inst[31:12]<<12).
  - OP-IMM 0010011: src1=rs1_data; src2=sext(inst[31:20]). f3 000 add, 010 slt, 011 sltu, 100 xor, 110 or, 111 and, 001 sll (inst[31:26]=0 else illegal), 101 srl if inst[31:26]=000000, sra if 010000, else illegal. Shifts: src2=zext(inst[25:20]).
  - OP 0110011: src1=rs1_data, src2=rs2_data. funct7 0000000: f3 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl, 110 or, 111 and. funct7 0100000: f3 000 sub, 101 sra; other f3 illegal. Any other funct7 (incl. 0000001 M-ext) illegal.
  - OP-IMM-32 0011011: alu_32=1. f3 000 add (src2=sext imm); 001 sll, 101 srl/sra per inst[31:25] 0000000/0100000, src2=zext(inst[24:20]); inst[25]=1 or other f3 illegal.
  - OP-32 0111011: alu_32=1; f3/funct7 000/0000000 add, 000/0100000 sub, 001/0000000 sll, 101/0000000 srl, 101/0100000 sra; others illegal.
  - Any other opcode: illegal.
- Illegal: alu_op=0, alu_32=0, rf_we=0, illegal=1; src1/src2=0; still handshakes as a normal entry.
- rd=inst[11:7]; rf_we=~illegal & (rd!=0).
- Exactly one alu_op bit set for legal entries.

Test Plan:
- addi x5,x1,-1 (0xFFF08293), rs1_data=0x10 -> next cycle out_valid=1, alu_op=0x0800, src1=0x10, src2=0xFFFFFFFFFFFFFFFF, rd=5, rf_we=1, alu_32=0.
- sub x3,x1,x2 (0x402081B3) then sraiw x4,x4,3 (0x4032521B) back-to-back, out_ready=1 -> alu_op 0x0400 then 0x0004 with alu_32=1, src2=3; in_ready stays 1, no bubble.
- lui x1,0x80000 (0x800000B7) -> alu_op=0x0002, src1=0, src2=0xFFFFFFFF80000000; addi x0,x0,0 (0x00000013) -> rf_we=0.
- mul x1,x1,x2 (0x022080B3) and slliw with inst[25]=1 -> illegal=1, alu_op=0, rf_we=0, out_valid=1.
- Backpressure: entry held, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs bit-stable; out_ready=1 -> next instruction accepted same edge.
- flush with held entry and in_valid=1 -> in_ready=0, out_valid=0 next cycle, instruction not issued; rst mid-stall -> all outputs 0 next cycle.
